// File: rtl/vedic_seq_mul16_if.sv
// Operand/result handshake bundle for the sequential 16x16 Vedic multiplier.
// The slave modport is the multiplier. The master modport is the operand
// source combined with the result consumer.
interface vedic_seq_mul16_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] p;
   logic        busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, p, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, p, busy
   );
endinterface

// File: rtl/vedic_seq_mul16.sv
// Sequential 16x16 unsigned multiplier.
// One combinational Vedic 8x8 core is reused over four cycles, once per
// byte-pair partial product. The partial products are shift-accumulated
// into a 32-bit result, which is held until the consumer takes it.

// 2x2 Vedic (Urdhva Tiryagbhyam) multiplier built from half adders.
module vedic_2x2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] c
);
   logic t1, t2, t3, k1;

   assign t1   = a[1] & b[0];
   assign t2   = a[0] & b[1];
   assign t3   = a[1] & b[1];
   assign k1   = t1 & t2;
   assign c[0] = a[0] & b[0];
   assign c[1] = t1 ^ t2;
   assign c[2] = t3 ^ k1;
   assign c[3] = t3 & k1;
endmodule

// 4x4 built from four 2x2 blocks.
// The vertical and crosswise terms are summed at their weights.
module vedic_4x4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] c
);
   logic [3:0] q0, q1, q2, q3;

   vedic_2x2 u_q0 (.a(a[1:0]), .b(b[1:0]), .c(q0));
   vedic_2x2 u_q1 (.a(a[3:2]), .b(b[1:0]), .c(q1));
   vedic_2x2 u_q2 (.a(a[1:0]), .b(b[3:2]), .c(q2));
   vedic_2x2 u_q3 (.a(a[3:2]), .b(b[3:2]), .c(q3));

   assign c = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
endmodule

// 8x8 core shared by the controller, built from four 4x4 blocks.
module vedic_8X8 (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] c
);
   logic [7:0] q0, q1, q2, q3;

   vedic_4x4 u_q0 (.a(a[3:0]), .b(b[3:0]), .c(q0));
   vedic_4x4 u_q1 (.a(a[7:4]), .b(b[3:0]), .c(q1));
   vedic_4x4 u_q2 (.a(a[3:0]), .b(b[7:4]), .c(q2));
   vedic_4x4 u_q3 (.a(a[7:4]), .b(b[7:4]), .c(q3));

   assign c = {8'b0, q0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {q3, 8'b0};
endmodule

// Controller: accept -> four MUL steps -> DONE until the result is taken.
module vedic_seq_mul16 (
   input  logic              clk,
   input  logic              rst,
   vedic_seq_mul16_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  step_q, step_d;
   logic [15:0] ar_q, ar_d;
   logic [15:0] br_q, br_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] p_q, p_d;

   logic [7:0]  core_a, core_b;
   logic [15:0] core_c;
   logic [31:0] term;

   vedic_8X8 u_core (.a(core_a), .b(core_b), .c(core_c));

   // Select the step's operand bytes and place the partial product at its weight.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      core_a = ar_q[7:0];
      core_b = br_q[7:0];
      term   = {16'b0, core_c};
      case (step_q)
         2'd0: begin
            core_a = ar_q[7:0];
            core_b = br_q[7:0];
            term   = {16'b0, core_c};
         end
         2'd1: begin
            core_a = ar_q[7:0];
            core_b = br_q[15:8];
            term   = {8'b0, core_c, 8'b0};
         end
         2'd2: begin
            core_a = ar_q[15:8];
            core_b = br_q[7:0];
            term   = {8'b0, core_c, 8'b0};
         end
         2'd3: begin
            core_a = ar_q[15:8];
            core_b = br_q[15:8];
            term   = {core_c, 16'b0};
         end
         default: ;
      endcase
   end

   // Next-state logic for the FSM, the step counter, the accumulator and the result.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      ar_d    = ar_q;
      br_d    = br_q;
      acc_d   = acc_q;
      p_d     = p_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d = MUL;
               ar_d    = bus.a;
               br_d    = bus.b;
               acc_d   = '0;
               step_d  = 2'd0;
            end
         end
         MUL: begin
            acc_d  = acc_q + term;
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) begin
               p_d     = acc_q + term;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state, accumulator and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q <= IDLE;
         step_q  <= 2'd0;
         acc_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         acc_q   <= acc_d;
         p_q     <= p_d;
      end
   end

   // Operand latches are not reset.
   always_ff @(posedge clk) begin
      // NOTE: ar/br are always loaded at accept before they are read, so they need no reset.
      ar_q <= ar_d;
      br_q <= br_d;
   end

   // Handshake outputs depend only on registered state.
   // in_ready is also held low while reset is high.
   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.p         = p_q;
endmodule
